cqt1_cfg_mgmt_bridge: RTL and testbench
=======================================

Name: cqt1_cfg_mgmt_bridge

Overview:
Sequential successor to the combinational Type 1 CQ to CFG MGMT decode on the DSP side of the two-port switch (CPM5 DSP, PL-PCIe5 USP). It accepts one Type 1 config request beat from the CQ stream and runs the full cfg_mgmt handshake, holding read/write until done or timeout. It then returns a PCIe completion on the CC stream, with data for reads and without data for writes. Target functions are parametrised, with UR for out-of-range functions and CA on timeout.

Parameters:
DSP_IF_WIDTH, 512, CQ/CC tdata width (>=256)
DSP_TKEEP_WIDTH, 16, dword tkeep width (DSP_IF_WIDTH/32)
DSP_CQ_TUSER_WIDTH, 231, CQ tuser width
DSP_CC_TUSER_WIDTH, 81, CC tuser width
NUM_FUNCTIONS, 1, number of valid target functions (1..256)
CFG_SELECT, 2'b01, value of select that routes CQ to this block
TIMEOUT_CYCLES, 1024, cycles to wait for cfg_mgmt_read_write_done (>=2)

Ports:
user_clk  in  1  block clock
user_reset_n  in  1  asynchronous active-low reset
dsp_m_axis_cq_tdata  in  DSP_IF_WIDTH  CQ descriptor+payload
dsp_m_axis_cq_tkeep  in  DSP_TKEEP_WIDTH  CQ keep
dsp_m_axis_cq_tlast  in  1  CQ last
dsp_m_axis_cq_tuser  in  DSP_CQ_TUSER_WIDTH  CQ user; [3:0] first BE
dsp_m_axis_cq_tvalid  in  1  CQ valid
dsp_m_axis_cq_tready  out  1  CQ ready from this block
select  in  2  CQ routing select
req_type  in  4  decoded CQ request type
dsp_s_axis_cc_tdata  out  DSP_IF_WIDTH  completion descriptor+data
dsp_s_axis_cc_tkeep  out  DSP_TKEEP_WIDTH  CC keep
dsp_s_axis_cc_tlast  out  1  always 1 while valid
dsp_s_axis_cc_tuser  out  DSP_CC_TUSER_WIDTH  tied 0
dsp_s_axis_cc_tvalid  out  1  CC valid
dsp_s_axis_cc_tready  in  1  CC ready
cfg_mgmt_addr  out  10  dword register address
cfg_mgmt_function_number  out  16  target function
cfg_mgmt_write  out  1  write strobe (held)
cfg_mgmt_write_data  out  32  write data
cfg_mgmt_byte_enable  out  4  byte enables
cfg_mgmt_read  out  1  read strobe (held)
cfg_mgmt_read_data  in  32  read data
cfg_mgmt_read_write_done  in  1  op complete
cfg_mgmt_debug_access  out  1  tied 0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, timeout counter 0. Reset mid-operation aborts the op and discards the pending completion.
- Hit = cq_tvalid & select==CFG_SELECT & req_type[3:2]==2'b10. cq_tready = (state==IDLE | state==DRAIN) & select==CFG_SELECT.
- IDLE: on hit & tready, register these fields:
  - addr tdata[11:2], requester ID [95:80], tag [103:96], function [111:104], TC [123:121], attr [126:124];
  - write = req_type[1], data [159:128], first BE tuser[3:0];
  - ur = function >= NUM_FUNCTIONS.
- From IDLE, go to DRAIN if !tlast, else CPL if ur, else ISSUE.
- DRAIN: accept beats until tlast, then CPL if ur, else ISSUE.
- ISSUE (1 cycle): drive cfg_mgmt_addr/function/byte_enable/write_data, assert cfg_mgmt_write or cfg_mgmt_read. Go to WAIT.
- WAIT:
  - Strobes and fields stay stable. Counter increments each cycle.
  - On done: capture read_data, status=SC, deassert strobes next cycle, go to CPL.
  - If counter reaches TIMEOUT_CYCLES-1 without done: status=CA (3'b100), deassert strobes, go to CPL.
  - Done on the same cycle as the timeout: done wins (SC).
- cfg_mgmt_read/write are never high together, and never high outside ISSUE/WAIT.
- CPL: cc_tvalid=1, and the completion is held stable until cc_tready. On accept go to IDLE; a new CQ beat can be accepted the following cycle.
- CC descriptor fields, all others 0:
  - lower addr [6:0] = {addr[4:0],2'b00};
  - byte count [28:16] = 4;
  - dword count [42:32] = 1 for SC read, else 0;
  - status [45:43] = SC 000 / UR 001 / CA 100;
  - requester ID [63:48], tag [71:64];
  - completer ID [87:72] = {8'b0, function};
  - TC [91:89], attr [94:92].
- CC data [127:96] = read_data for an SC read.
- cc_tkeep = 0xF for an SC read, else 0x7.
- Latency from the accept cycle: cc_tvalid rises 3 cycles after accept when done returns in the first WAIT cycle. A UR completion appears 1 cycle after the last CQ beat.

Decomposition:
- Package cfg_bridge_pkg holds:
  - state enum {IDLE, DRAIN, ISSUE, WAIT, CPL};
  - completion status constants CPL_SC, CPL_UR, CPL_CA;
  - CQ/CC descriptor bit-position localparams;
  - a packed struct for the captured request.
- Sub-module cc_cpl_builder: combinational, maps the captured request, status and data to cc_tdata/tkeep.

Test Plan:
- Write: req_type 4'b1010, addr 0x040, data 0xDEADBEEF, BE 0xF, tag 0x12, done after 3 cycles -> cfg_mgmt_write held 4 cycles with addr 0x010; CC status 000, dword count 0, tkeep 0x7, tag 0x12.
- Read: req_type 4'b1000, addr 0x008, read_data 0x12345678, done 1 cycle after ISSUE -> CC dword count 1, data 0x12345678, lower addr 0x08, tkeep 0xF.
- Out-of-range function 8'h01 with NUM_FUNCTIONS=1 -> no cfg_mgmt strobe; CC status 001.
- No done, TIMEOUT_CYCLES=16 -> strobe drops after 16 cycles; CC status 100.
- CC backpressure: cc_tready low 5 cycles -> CC outputs stable, cq_tready 0 throughout; the next request is accepted the cycle after the CC handshake.
- Reset: user_reset_n low during WAIT -> all outputs 0 asynchronously; no CC issued after release.

Source files
------------

// File: rtl/cfg_bridge_pkg.sv
// Shared types for the Type 1 CQ -> cfg_mgmt bridge: FSM states, completion
// status codes, CQ/CC descriptor bit positions and the captured request.
// Ports: none (package).
package cfg_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    CPL   = 3'd4
  } state_e;

  localparam logic [2:0] CPL_SC = 3'b000;
  localparam logic [2:0] CPL_UR = 3'b001;
  localparam logic [2:0] CPL_CA = 3'b100;

  // CQ descriptor fields (low bit positions)
  localparam int CQ_ADDR_LO  = 2;
  localparam int CQ_REQID_LO = 80;
  localparam int CQ_TAG_LO   = 96;
  localparam int CQ_FUNC_LO  = 104;
  localparam int CQ_TC_LO    = 121;
  localparam int CQ_ATTR_LO  = 124;
  localparam int CQ_DATA_LO  = 128;

  // CC descriptor fields (low bit positions)
  localparam int CC_LADDR_LO  = 0;
  localparam int CC_BCNT_LO   = 16;
  localparam int CC_DWCNT_LO  = 32;
  localparam int CC_STAT_LO   = 43;
  localparam int CC_REQID_LO  = 48;
  localparam int CC_TAG_LO    = 64;
  localparam int CC_CPLID_LO  = 72;
  localparam int CC_TC_LO     = 89;
  localparam int CC_ATTR_LO   = 92;
  localparam int CC_DATA_LO   = 96;

  typedef struct packed {
    logic [9:0]  addr;
    logic [15:0] req_id;
    logic [7:0]  tag;
    logic [7:0]  func;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic        write;
    logic [31:0] data;
    logic [3:0]  be;
  } cfg_req_t;

  // Pull the fields of one Type 1 config request out of the first CQ beat.
  function automatic cfg_req_t cq_capture(input logic [159:0] hdr,
                                          input logic [3:0]   rtype,
                                          input logic [3:0]   first_be);
    cfg_req_t r;
    r.addr   = hdr[CQ_ADDR_LO  +: 10];
    r.req_id = hdr[CQ_REQID_LO +: 16];
    r.tag    = hdr[CQ_TAG_LO   +: 8];
    r.func   = hdr[CQ_FUNC_LO  +: 8];
    r.tc     = hdr[CQ_TC_LO    +: 3];
    r.attr   = hdr[CQ_ATTR_LO  +: 3];
    r.write  = rtype[1];
    r.data   = hdr[CQ_DATA_LO  +: 32];
    r.be     = first_be;
    return r;
  endfunction

endpackage

// File: rtl/cc_cpl_builder.sv
// Builds the single-beat CC completion (descriptor + optional dword) from the
// captured request, completion status and captured read data.
// Latency: combinational. Backpressure: none, the caller holds the inputs.
// Ports: req/status/rdata in; cc_tdata/cc_tkeep out.
module cc_cpl_builder
  import cfg_bridge_pkg::*;
#(
  parameter int DSP_IF_WIDTH    = 512,
  parameter int DSP_TKEEP_WIDTH = 16
) (
  input  cfg_req_t                   req,
  input  logic [2:0]                 status,
  input  logic [31:0]                rdata,
  output logic [DSP_IF_WIDTH-1:0]    cc_tdata,
  output logic [DSP_TKEEP_WIDTH-1:0] cc_tkeep
);

  logic sc_read;
  logic unused_ok;

  assign sc_read   = (status == CPL_SC) && !req.write;
  assign unused_ok = ^{req.data, req.be};

  always_comb begin
    cc_tdata = '0;
    cc_tdata[CC_LADDR_LO +: 7]  = {req.addr[4:0], 2'b00};
    cc_tdata[CC_BCNT_LO  +: 13] = 13'd4;
    cc_tdata[CC_DWCNT_LO +: 11] = sc_read ? 11'd1 : 11'd0;
    cc_tdata[CC_STAT_LO  +: 3]  = status;
    cc_tdata[CC_REQID_LO +: 16] = req.req_id;
    cc_tdata[CC_TAG_LO   +: 8]  = req.tag;
    cc_tdata[CC_CPLID_LO +: 16] = {8'h00, req.func};
    cc_tdata[CC_TC_LO    +: 3]  = req.tc;
    cc_tdata[CC_ATTR_LO  +: 3]  = req.attr;
    if (sc_read) begin
      cc_tdata[CC_DATA_LO +: 32] = rdata;
    end
    cc_tkeep      = '0;
    cc_tkeep[3:0] = sc_read ? 4'hF : 4'h7;
  end

endmodule

// File: rtl/cqt1_cfg_mgmt_bridge.sv
// Type 1 CQ config request -> cfg_mgmt read/write -> CC completion bridge.
// Latency: CC valid 3 cycles after accept (done in first WAIT cycle); UR 1 cycle after last beat.
// Backpressure: CQ ready only in IDLE/DRAIN; completion held stable until cc_tready.
// Ports: user_clk/user_reset_n; CQ stream in (+select/req_type); CC stream out;
//        cfg_mgmt request/response; busy status.
module cqt1_cfg_mgmt_bridge
  import cfg_bridge_pkg::*;
#(
  parameter int         DSP_IF_WIDTH       = 512,
  parameter int         DSP_TKEEP_WIDTH    = 16,
  parameter int         DSP_CQ_TUSER_WIDTH = 231,
  parameter int         DSP_CC_TUSER_WIDTH = 81,
  parameter int         NUM_FUNCTIONS      = 1,
  parameter logic [1:0] CFG_SELECT         = 2'b01,
  parameter int         TIMEOUT_CYCLES     = 1024
) (
  input  logic                          user_clk,
  input  logic                          user_reset_n,
  input  logic [DSP_IF_WIDTH-1:0]       dsp_m_axis_cq_tdata,
  input  logic [DSP_TKEEP_WIDTH-1:0]    dsp_m_axis_cq_tkeep,
  input  logic                          dsp_m_axis_cq_tlast,
  input  logic [DSP_CQ_TUSER_WIDTH-1:0] dsp_m_axis_cq_tuser,
  input  logic                          dsp_m_axis_cq_tvalid,
  output logic                          dsp_m_axis_cq_tready,
  input  logic [1:0]                    select,
  input  logic [3:0]                    req_type,
  output logic [DSP_IF_WIDTH-1:0]       dsp_s_axis_cc_tdata,
  output logic [DSP_TKEEP_WIDTH-1:0]    dsp_s_axis_cc_tkeep,
  output logic                          dsp_s_axis_cc_tlast,
  output logic [DSP_CC_TUSER_WIDTH-1:0] dsp_s_axis_cc_tuser,
  output logic                          dsp_s_axis_cc_tvalid,
  input  logic                          dsp_s_axis_cc_tready,
  output logic [9:0]                    cfg_mgmt_addr,
  output logic [15:0]                   cfg_mgmt_function_number,
  output logic                          cfg_mgmt_write,
  output logic [31:0]                   cfg_mgmt_write_data,
  output logic [3:0]                    cfg_mgmt_byte_enable,
  output logic                          cfg_mgmt_read,
  input  logic [31:0]                   cfg_mgmt_read_data,
  input  logic                          cfg_mgmt_read_write_done,
  output logic                          cfg_mgmt_debug_access,
  output logic                          busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  cfg_req_t         req_q, req_d;
  logic             ur_q, ur_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       status_q, status_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [9:0]       mg_addr_q, mg_addr_d;
  logic [15:0]      mg_func_q, mg_func_d;
  logic [31:0]      mg_wdata_q, mg_wdata_d;
  logic [3:0]       mg_be_q, mg_be_d;
  logic             mg_wr_q, mg_wr_d;
  logic             mg_rd_q, mg_rd_d;
  logic             cc_vld_q, cc_vld_d;

  logic             cq_rdy;
  logic             cq_beat;
  cfg_req_t         cap;
  cfg_req_t         launch_req;
  logic             launch, launch_ur, finish;
  logic [DSP_IF_WIDTH-1:0]    bld_tdata;
  logic [DSP_TKEEP_WIDTH-1:0] bld_tkeep;
  logic             unused_ok;

  // Ready is qualified by reset so every output reads 0 while held in reset.
  assign cq_rdy  = user_reset_n && (select == CFG_SELECT) &&
                   ((state_q == IDLE) || (state_q == DRAIN));
  assign cq_beat = dsp_m_axis_cq_tvalid && cq_rdy;
  assign cap     = cq_capture(dsp_m_axis_cq_tdata[159:0], req_type,
                              dsp_m_axis_cq_tuser[3:0]);

  assign unused_ok = ^{dsp_m_axis_cq_tdata, dsp_m_axis_cq_tkeep,
                       dsp_m_axis_cq_tuser, req_type[0]};

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    ur_d       = ur_q;
    cnt_d      = cnt_q;
    status_d   = status_q;
    rdata_d    = rdata_q;
    mg_addr_d  = mg_addr_q;
    mg_func_d  = mg_func_q;
    mg_wdata_d = mg_wdata_q;
    mg_be_d    = mg_be_q;
    mg_wr_d    = mg_wr_q;
    mg_rd_d    = mg_rd_q;
    cc_vld_d   = cc_vld_q;
    launch     = 1'b0;
    launch_req = req_q;
    launch_ur  = ur_q;
    finish     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cq_beat && (req_type[3:2] == 2'b10)) begin
          req_d      = cap;
          ur_d       = ({24'd0, cap.func} >= 32'(NUM_FUNCTIONS));
          launch_req = cap;
          launch_ur  = ur_d;
          if (dsp_m_axis_cq_tlast) launch  = 1'b1;
          else                     state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cq_beat && dsp_m_axis_cq_tlast) launch = 1'b1;
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // done is checked first so a done on the last timeout cycle still wins
        if (cfg_mgmt_read_write_done) begin
          rdata_d  = cfg_mgmt_read_data;
          status_d = CPL_SC;
          finish   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          status_d = CPL_CA;
          finish   = 1'b1;
        end
      end
      CPL: begin
        if (dsp_s_axis_cc_tready) begin
          cc_vld_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Last CQ beat seen: either complete with UR straight away or start the op.
    if (launch) begin
      if (launch_ur) begin
        status_d = CPL_UR;
        cc_vld_d = 1'b1;
        state_d  = CPL;
      end else begin
        state_d    = ISSUE;
        mg_addr_d  = launch_req.addr;
        mg_func_d  = {8'h00, launch_req.func};
        mg_wdata_d = launch_req.data;
        mg_be_d    = launch_req.be;
        mg_wr_d    = launch_req.write;
        mg_rd_d    = !launch_req.write;
      end
    end

    if (finish) begin
      mg_wr_d  = 1'b0;
      mg_rd_d  = 1'b0;
      cc_vld_d = 1'b1;
      cnt_d    = '0;
      state_d  = CPL;
    end
  end

  always_ff @(posedge user_clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q    <= IDLE;
      req_q      <= '0;
      ur_q       <= 1'b0;
      cnt_q      <= '0;
      status_q   <= '0;
      rdata_q    <= '0;
      mg_addr_q  <= '0;
      mg_func_q  <= '0;
      mg_wdata_q <= '0;
      mg_be_q    <= '0;
      mg_wr_q    <= 1'b0;
      mg_rd_q    <= 1'b0;
      cc_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ur_q       <= ur_d;
      cnt_q      <= cnt_d;
      status_q   <= status_d;
      rdata_q    <= rdata_d;
      mg_addr_q  <= mg_addr_d;
      mg_func_q  <= mg_func_d;
      mg_wdata_q <= mg_wdata_d;
      mg_be_q    <= mg_be_d;
      mg_wr_q    <= mg_wr_d;
      mg_rd_q    <= mg_rd_d;
      cc_vld_q   <= cc_vld_d;
    end
  end

  cc_cpl_builder #(
    .DSP_IF_WIDTH    (DSP_IF_WIDTH),
    .DSP_TKEEP_WIDTH (DSP_TKEEP_WIDTH)
  ) u_cc_cpl_builder (
    .req      (req_q),
    .status   (status_q),
    .rdata    (rdata_q),
    .cc_tdata (bld_tdata),
    .cc_tkeep (bld_tkeep)
  );

  // The completion is only presented while valid, so idle/reset reads all-zero.
  assign dsp_s_axis_cc_tdata      = cc_vld_q ? bld_tdata : '0;
  assign dsp_s_axis_cc_tkeep      = cc_vld_q ? bld_tkeep : '0;
  assign dsp_s_axis_cc_tlast      = cc_vld_q;
  assign dsp_s_axis_cc_tuser      = '0;
  assign dsp_s_axis_cc_tvalid     = cc_vld_q;
  assign dsp_m_axis_cq_tready     = cq_rdy;
  assign cfg_mgmt_addr            = mg_addr_q;
  assign cfg_mgmt_function_number = mg_func_q;
  assign cfg_mgmt_write           = mg_wr_q;
  assign cfg_mgmt_write_data      = mg_wdata_q;
  assign cfg_mgmt_byte_enable     = mg_be_q;
  assign cfg_mgmt_read            = mg_rd_q;
  assign cfg_mgmt_debug_access    = 1'b0;
  assign busy                     = (state_q != IDLE);

endmodule

// File: tb/tb_cqt1_cfg_mgmt_bridge.sv
// Directed bench for cqt1_cfg_mgmt_bridge: write, read, UR via a two-beat
// request, timeout (CA), CC backpressure with back-to-back request, and
// asynchronous reset during WAIT. Inputs change 1 ns after the rising edge.
module tb_cqt1_cfg_mgmt_bridge;

  localparam int W   = 512;
  localparam int K   = 16;
  localparam int CQU = 231;
  localparam int CCU = 81;

  logic           user_clk = 1'b0;
  logic           user_reset_n;
  logic [W-1:0]   cq_tdata;
  logic [K-1:0]   cq_tkeep;
  logic           cq_tlast;
  logic [CQU-1:0] cq_tuser;
  logic           cq_tvalid;
  logic           cq_tready;
  logic [1:0]     select;
  logic [3:0]     req_type;
  logic [W-1:0]   cc_tdata;
  logic [K-1:0]   cc_tkeep;
  logic           cc_tlast;
  logic [CCU-1:0] cc_tuser;
  logic           cc_tvalid;
  logic           cc_tready;
  logic [9:0]     mg_addr;
  logic [15:0]    mg_func;
  logic           mg_write;
  logic [31:0]    mg_wdata;
  logic [3:0]     mg_be;
  logic           mg_read;
  logic [31:0]    mg_rdata;
  logic           mg_done;
  logic           mg_dbg;
  logic           busy;

  always #5 user_clk = ~user_clk;

  cqt1_cfg_mgmt_bridge #(
    .DSP_IF_WIDTH       (W),
    .DSP_TKEEP_WIDTH    (K),
    .DSP_CQ_TUSER_WIDTH (CQU),
    .DSP_CC_TUSER_WIDTH (CCU),
    .NUM_FUNCTIONS      (1),
    .CFG_SELECT         (2'b01),
    .TIMEOUT_CYCLES     (16)
  ) dut (
    .user_clk                 (user_clk),
    .user_reset_n             (user_reset_n),
    .dsp_m_axis_cq_tdata      (cq_tdata),
    .dsp_m_axis_cq_tkeep      (cq_tkeep),
    .dsp_m_axis_cq_tlast      (cq_tlast),
    .dsp_m_axis_cq_tuser      (cq_tuser),
    .dsp_m_axis_cq_tvalid     (cq_tvalid),
    .dsp_m_axis_cq_tready     (cq_tready),
    .select                   (select),
    .req_type                 (req_type),
    .dsp_s_axis_cc_tdata      (cc_tdata),
    .dsp_s_axis_cc_tkeep      (cc_tkeep),
    .dsp_s_axis_cc_tlast      (cc_tlast),
    .dsp_s_axis_cc_tuser      (cc_tuser),
    .dsp_s_axis_cc_tvalid     (cc_tvalid),
    .dsp_s_axis_cc_tready     (cc_tready),
    .cfg_mgmt_addr            (mg_addr),
    .cfg_mgmt_function_number (mg_func),
    .cfg_mgmt_write           (mg_write),
    .cfg_mgmt_write_data      (mg_wdata),
    .cfg_mgmt_byte_enable     (mg_be),
    .cfg_mgmt_read            (mg_read),
    .cfg_mgmt_read_data       (mg_rdata),
    .cfg_mgmt_read_write_done (mg_done),
    .cfg_mgmt_debug_access    (mg_dbg),
    .busy                     (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Monitor on the falling edge: counts strobe cycles and CC handshakes.
  int           wr_hi, rd_hi, both_hi, cc_cnt;
  logic [127:0] cc_dat;
  logic [K-1:0] cc_keep;

  always @(negedge user_clk) begin
    if (user_reset_n) begin
      if (mg_write) wr_hi++;
      if (mg_read) rd_hi++;
      if (mg_write && mg_read) both_hi++;
      if (cc_tvalid && cc_tready) begin
        cc_cnt++;
        cc_dat  = cc_tdata[127:0];
        cc_keep = cc_tkeep;
      end
    end
  end

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  task automatic clr_cnt();
    wr_hi = 0; rd_hi = 0; cc_cnt = 0; cc_dat = '0; cc_keep = '0;
  endtask

  task automatic put_beat(input logic [3:0] rt, input logic [11:0] baddr,
                          input logic [7:0] func, input logic [7:0] tag,
                          input logic [31:0] data, input logic last);
    cq_tdata            = '0;
    cq_tdata[11:0]      = baddr;
    cq_tdata[95:80]     = 16'hABCD;
    cq_tdata[103:96]    = tag;
    cq_tdata[111:104]   = func;
    cq_tdata[123:121]   = 3'b010;
    cq_tdata[126:124]   = 3'b001;
    cq_tdata[159:128]   = data;
    cq_tuser            = '0;
    cq_tuser[3:0]       = 4'hF;
    cq_tkeep            = '1;
    cq_tlast            = last;
    req_type            = rt;
    cq_tvalid           = 1'b1;
  endtask

  // Single-beat request: present, confirm ready, let it be accepted.
  task automatic beat(input string tag, input logic [3:0] rt, input logic [11:0] baddr,
                      input logic [7:0] func, input logic [7:0] ctag, input logic [31:0] data);
    put_beat(rt, baddr, func, ctag, data, 1'b1);
    #1;
    chk({tag, "_cq_tready"}, cq_tready, 1);
    tick();
    cq_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [127:0] snap;
    both_hi = 0;
    clr_cnt();
    user_reset_n = 1'b0;
    cq_tdata = '0; cq_tkeep = '0; cq_tlast = 1'b0; cq_tuser = '0; cq_tvalid = 1'b0;
    select = 2'b01; req_type = 4'h0; cc_tready = 1'b1; mg_rdata = '0; mg_done = 1'b0;

    // ---- reset state
    repeat (3) tick();
    chk("rst_cq_tready", cq_tready, 0);
    chk("rst_cc_tvalid", cc_tvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cc_tkeep", cc_tkeep, 0);
    user_reset_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_cq_tready", cq_tready, 1);
    chk("idle_write", mg_write, 0);

    // ---- write, done in third WAIT cycle
    clr_cnt();
    beat("wr", 4'b1010, 12'h040, 8'h00, 8'h12, 32'hDEADBEEF);
    chk("wr_issue_write", mg_write, 1);
    chk("wr_issue_read", mg_read, 0);
    chk("wr_addr", mg_addr, 10'h010);
    chk("wr_wdata", mg_wdata, 32'hDEADBEEF);
    chk("wr_be", mg_be, 4'hF);
    chk("wr_func", mg_func, 16'h0000);
    chk("wr_busy", busy, 1);
    chk("wr_cq_tready", cq_tready, 0);
    repeat (3) tick();
    mg_done = 1'b1;
    tick();
    mg_done = 1'b0;
    chk("wr_cc_tvalid", cc_tvalid, 1);
    chk("wr_cc_tlast", cc_tlast, 1);
    chk("wr_strobe_off", mg_write, 0);
    tick();
    chk("wr_strobe_cycles", wr_hi, 4);
    chk("wr_no_read", rd_hi, 0);
    chk("wr_cc_count", cc_cnt, 1);
    chk("wr_status", cc_dat[45:43], 3'b000);
    chk("wr_dwcnt", cc_dat[42:32], 0);
    chk("wr_bytecnt", cc_dat[28:16], 4);
    chk("wr_laddr", cc_dat[6:0], 7'h40);
    chk("wr_tag", cc_dat[71:64], 8'h12);
    chk("wr_reqid", cc_dat[63:48], 16'hABCD);
    chk("wr_tc", cc_dat[91:89], 3'b010);
    chk("wr_attr", cc_dat[94:92], 3'b001);
    chk("wr_tkeep", cc_keep, 16'h0007);
    chk("wr_back_idle", busy, 0);

    // ---- read, done in first WAIT cycle: CC valid 3 cycles after accept
    clr_cnt();
    mg_rdata = 32'h12345678;
    beat("rd", 4'b1000, 12'h008, 8'h00, 8'h34, 32'h0);
    chk("rd_issue_read", mg_read, 1);
    chk("rd_addr", mg_addr, 10'h002);
    tick();
    mg_done = 1'b1;
    chk("rd_cc_early", cc_tvalid, 0);
    tick();
    mg_done = 1'b0;
    chk("rd_cc_tvalid", cc_tvalid, 1);
    chk("rd_strobe_off", mg_read, 0);
    tick();
    chk("rd_strobe_cycles", rd_hi, 2);
    chk("rd_status", cc_dat[45:43], 3'b000);
    chk("rd_dwcnt", cc_dat[42:32], 1);
    chk("rd_data", cc_dat[127:96], 32'h12345678);
    chk("rd_laddr", cc_dat[6:0], 7'h08);
    chk("rd_tag", cc_dat[71:64], 8'h34);
    chk("rd_tkeep", cc_keep, 16'h000F);

    // ---- out-of-range function, two-beat request (through DRAIN) -> UR
    clr_cnt();
    put_beat(4'b1000, 12'h00C, 8'h01, 8'h56, 32'h0, 1'b0);
    #1;
    chk("ur_cq_tready", cq_tready, 1);
    tick();
    chk("ur_drain_busy", busy, 1);
    chk("ur_drain_rdy", cq_tready, 1);
    chk("ur_drain_cc", cc_tvalid, 0);
    cq_tlast = 1'b1;
    tick();
    cq_tvalid = 1'b0;
    chk("ur_cc_tvalid", cc_tvalid, 1);
    tick();
    chk("ur_no_strobe", wr_hi + rd_hi, 0);
    chk("ur_status", cc_dat[45:43], 3'b001);
    chk("ur_dwcnt", cc_dat[42:32], 0);
    chk("ur_cplid", cc_dat[87:72], 16'h0001);
    chk("ur_tag", cc_dat[71:64], 8'h56);
    chk("ur_tkeep", cc_keep, 16'h0007);

    // ---- timeout: no done, ISSUE + 16 WAIT cycles of strobe then CA
    clr_cnt();
    beat("to", 4'b1000, 12'h010, 8'h00, 8'h78, 32'h0);
    cyc = 0;
    while (!cc_tvalid && cyc < 64) begin
      tick();
      cyc++;
    end
    chk("to_cpl_delay", cyc, 17);
    chk("to_strobe_off", mg_read, 0);
    tick();
    chk("to_strobe_cycles", rd_hi, 17);
    chk("to_status", cc_dat[45:43], 3'b100);
    chk("to_dwcnt", cc_dat[42:32], 0);
    chk("to_tkeep", cc_keep, 16'h0007);

    // ---- CC backpressure for 5 cycles, next request waiting on CQ
    clr_cnt();
    cc_tready = 1'b0;
    beat("bp", 4'b1010, 12'h020, 8'h00, 8'h9A, 32'h01020304);
    tick();
    mg_done = 1'b1;
    tick();
    mg_done = 1'b0;
    chk("bp_cc_tvalid", cc_tvalid, 1);
    snap = cc_tdata[127:0];
    mg_rdata = 32'hCAFEF00D;
    put_beat(4'b1000, 12'h004, 8'h00, 8'hBC, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_cq_tready", cq_tready, 0);
      chk("bp_cc_hold_vld", cc_tvalid, 1);
      chk("bp_cc_hold_dat", (cc_tdata[127:0] == snap) ? 64'd1 : 64'd0, 1);
      if (i == 4) cc_tready = 1'b1;
      tick();
    end
    chk("bp_cc_count", cc_cnt, 1);
    chk("bp_status", cc_dat[45:43], 3'b000);
    chk("bp_tag", cc_dat[71:64], 8'h9A);
    chk("bp_next_rdy", cq_tready, 1);
    tick();
    cq_tvalid = 1'b0;
    chk("bp_next_issue", mg_read, 1);
    tick();
    mg_done = 1'b1;
    tick();
    mg_done = 1'b0;
    tick();
    chk("bp2_cc_count", cc_cnt, 2);
    chk("bp2_tag", cc_dat[71:64], 8'hBC);
    chk("bp2_data", cc_dat[127:96], 32'hCAFEF00D);

    // ---- reset while in WAIT
    clr_cnt();
    beat("rs", 4'b1010, 12'h000, 8'h00, 8'h11, 32'h55AA55AA);
    tick();
    chk("rs_in_wait", mg_write, 1);
    user_reset_n = 1'b0;
    #1;
    chk("rs_write", mg_write, 0);
    chk("rs_read", mg_read, 0);
    chk("rs_addr_wdata", {22'd0, mg_addr, mg_wdata}, 0);
    chk("rs_busy", busy, 0);
    chk("rs_cc_tvalid", cc_tvalid, 0);
    chk("rs_cq_tready", cq_tready, 0);
    chk("rs_cc_tdata", cc_tdata[63:0], 0);
    tick();
    user_reset_n = 1'b1;
    repeat (20) tick();
    chk("rs_no_cc", cc_cnt, 0);
    chk("rs_idle", busy, 0);
    chk("rs_no_strobe", mg_write, 0);

    chk("never_both_strobes", both_hi, 0);
    chk("debug_access", mg_dbg, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
